// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage integer ALU for RV32I/RV64I with an optional
//               M extension. Base ops complete in one cycle. MUL/DIV ops
//               share one iterative shift-add / restoring-divide datapath,
//               with a final sign-correction cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN) + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_OUT  = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_FIX  = 3'd4;

    localparam logic [6:0]      OP_REG   = 7'b0110011;
    localparam logic [6:0]      OP_IMM   = 7'b0010011;
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opd;
    logic [2:0]      r_f3;
    logic            r_neg_p;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;
    logic            r_illegal;

    logic            w_accept;
    logic            w_is_reg;
    logic            w_is_imm;
    logic [XLEN-1:0] w_op_b;
    logic [SHW-1:0]  w_shamt;
    logic            w_sh_zero;
    logic            w_sh_alt;
    logic [XLEN-1:0] w_alu;
    logic            w_ill;
    logic            w_is_m;

    // Shift-immediate funct7 check; on RV64 funct7[0] carries shamt[5]
    generate
        if (XLEN == 64) begin : g_sh64
            assign w_sh_zero = (funct7[6:1] == 6'b000000);
            assign w_sh_alt  = (funct7[6:1] == 6'b010000);
        end else begin : g_sh32
            assign w_sh_zero = (funct7 == 7'b0000000);
            assign w_sh_alt  = (funct7 == 7'b0100000);
        end
    endgenerate

    assign w_is_reg = (opcode == OP_REG);
    assign w_is_imm = (opcode == OP_IMM);
    assign w_op_b   = w_is_imm ? imm : rs2_val;
    assign w_shamt  = w_op_b[SHW-1:0];

    // Single-cycle decode and base ALU; illegal combinations leave result at zero
    always_comb begin
        w_alu  = '0;
        w_ill  = 1'b0;
        w_is_m = 1'b0;
        if (w_is_reg && funct7 == 7'b0000000) begin
            case (funct3)
                3'b000:  w_alu = rs1_val + w_op_b;
                3'b001:  w_alu = rs1_val << w_shamt;
                3'b010:  w_alu = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(w_op_b)};
                3'b011:  w_alu = {{(XLEN-1){1'b0}}, rs1_val < w_op_b};
                3'b100:  w_alu = rs1_val ^ w_op_b;
                3'b101:  w_alu = rs1_val >> w_shamt;
                3'b110:  w_alu = rs1_val | w_op_b;
                default: w_alu = rs1_val & w_op_b;
            endcase
        end else if (w_is_reg && funct7 == 7'b0100000) begin
            case (funct3)
                3'b000:  w_alu = rs1_val - w_op_b;
                3'b101:  w_alu = $signed(rs1_val) >>> w_shamt;
                default: w_ill = 1'b1;
            endcase
        end else if (w_is_reg && funct7 == 7'b0000001 && ENABLE_M != 0) begin
            w_is_m = 1'b1;
        end else if (w_is_imm) begin
            case (funct3)
                3'b000:  w_alu = rs1_val + w_op_b;
                3'b001: begin
                    if (w_sh_zero) w_alu = rs1_val << w_shamt;
                    else           w_ill = 1'b1;
                end
                3'b010:  w_alu = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(w_op_b)};
                3'b011:  w_alu = {{(XLEN-1){1'b0}}, rs1_val < w_op_b};
                3'b100:  w_alu = rs1_val ^ w_op_b;
                3'b101: begin
                    if (w_sh_zero)     w_alu = rs1_val >> w_shamt;
                    else if (w_sh_alt) w_alu = $signed(rs1_val) >>> w_shamt;
                    else               w_ill = 1'b1;
                end
                3'b110:  w_alu = rs1_val | w_op_b;
                default: w_alu = rs1_val & w_op_b;
            endcase
        end else begin
            w_ill = 1'b1;
        end
    end

    // M-op operand preparation: magnitudes plus sign bookkeeping for the FIX cycle
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_is_div;
    logic            w_div0;
    logic            w_ovf;
    logic            w_m_fast;
    logic [XLEN-1:0] w_fast_res;

    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_a_neg    = w_a_signed & rs1_val[XLEN-1];
    assign w_b_neg    = w_b_signed & rs2_val[XLEN-1];
    assign w_a_mag    = w_a_neg ? -rs1_val : rs1_val;
    assign w_b_mag    = w_b_neg ? -rs2_val : rs2_val;
    assign w_is_div   = funct3[2];
    assign w_div0     = (rs2_val == '0);
    assign w_ovf      = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                        (rs1_val == MIN_NEG) && (rs2_val == '1);
    assign w_m_fast   = w_is_div && (w_div0 || w_ovf);
    // Divide-by-zero: quotient all-ones, remainder = dividend.
    // Overflow: quotient = dividend (the most negative value), remainder 0.
    assign w_fast_res = w_div0 ? (funct3[1] ? rs1_val : '1)
                               : (funct3[1] ? '0 : rs1_val);

    // One iteration of each algorithm on the shared {r_hi, r_lo} register pair
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opd};
    assign w_prod      = {r_hi, r_lo};
    assign w_prod_s    = r_neg_p ? -w_prod : w_prod;
    assign w_quo       = r_neg_p ? -r_lo : r_lo;
    assign w_rem       = r_neg_r ? -r_hi : r_hi;

    // Final result selection applied in the FIX cycle
    always_comb begin
        w_fix_res = '0;
        case (r_f3)
            3'b000:                 w_fix_res = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_rem;
        endcase
    end

    assign w_accept  = in_valid & in_ready;
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_OUT) && out_ready);
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
    assign result    = r_result;
    assign illegal   = r_illegal;

    // Control FSM and iterative datapath; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opd     <= '0;
            r_f3      <= '0;
            r_neg_p   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_OUT: begin
                    if (w_accept) begin
                        if (w_is_m && !w_m_fast) begin
                            r_state <= w_is_div ? S_DIV : S_MUL;
                            r_cnt   <= CNT_INIT;
                            r_hi    <= '0;
                            r_lo    <= w_a_mag;
                            r_opd   <= w_b_mag;
                            r_f3    <= funct3;
                            r_neg_p <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end else begin
                            r_state   <= S_OUT;
                            r_result  <= w_is_m ? w_fast_res : w_alu;
                            r_illegal <= w_ill;
                        end
                    end else if (r_state == S_OUT && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_hi  <= w_mul_sum[XLEN:1];
                    r_lo  <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_state <= S_FIX;
                end
                S_DIV: begin
                    r_hi  <= w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0];
                    r_lo  <= {r_lo[XLEN-2:0], ~w_div_diff[XLEN]};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result  <= w_fix_res;
                    r_illegal <= 1'b0;
                    r_state   <= S_OUT;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit (XLEN=32). Expected
//               results are queued as operations are driven and compared as
//               the DUT hands them off.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [31:0] imm = '0;
    logic        in_ready, out_valid, illegal, busy;
    logic [31:0] result;

    logic        nm_in_valid = 1'b0;
    logic        nm_out_ready = 1'b1;
    logic        nm_in_ready, nm_out_valid, nm_illegal, nm_busy;
    logic [31:0] nm_result;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .ENABLE_M(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal), .busy(busy)
    );

    alu_exec_unit #(.XLEN(32), .ENABLE_M(0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .out_valid(nm_out_valid), .out_ready(nm_out_ready),
        .result(nm_result), .illegal(nm_illegal), .busy(nm_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one op, wait (bounded) for acceptance, queue its expected result
    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] er, input logic ei, output int waits);
        opcode = op; funct3 = f3; funct7 = f7;
        rs1_val = a; rs2_val = b; imm = im;
        in_valid = 1'b1;
        #1;
        waits = 0;
        while (!in_ready && waits < 200) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!in_ready) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
        exp_q.push_back({ei, er});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from accept to out_valid; busy/in_ready must hold while waiting
    task automatic wait_out(input string tag, input int exp_lat);
        int n = 0;
        logic ok = 1'b1;
        while (!out_valid && n < 200) begin
            if (!(busy === 1'b1 && in_ready === 1'b0)) ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        if (exp_lat > 0) chk({tag, "_busy"}, {63'd0, ok}, 64'd1);
    endtask

    // Scoreboard: compare each handed-off result against the queue head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", {31'd0, illegal, result}, 64'h1_FFFF_FFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("sb_result", {31'd0, illegal, result}, {31'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // Reset state
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // SUB on the single-cycle path
        drive(OP_REG, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE, 1'b0, w);
        wait_out("sub", 0);
        // Undefined funct3 under funct7 0100000
        drive(OP_REG, 3'b001, 7'b0100000, 32'd5, 32'd7, 32'd0, 32'h0, 1'b1, w);
        wait_out("bad_alt", 0);
        // Shift-immediate decode
        drive(OP_IMM, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0, 32'd4, 32'hF800_0000, 1'b0, w);
        wait_out("srai", 0);
        drive(OP_IMM, 3'b101, 7'b0000000, 32'h8000_0000, 32'd0, 32'd4, 32'h0800_0000, 1'b0, w);
        wait_out("srli", 0);
        drive(OP_IMM, 3'b101, 7'b0000001, 32'h8000_0000, 32'd0, 32'd4, 32'h0, 1'b1, w);
        wait_out("sri_bad", 0);
        drive(OP_IMM, 3'b011, 7'b0000000, 32'd3, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, w);
        wait_out("sltiu", 0);

        // Multiply family
        drive(OP_REG, 3'b001, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, w);
        wait_out("mulh", 33);
        drive(OP_REG, 3'b011, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h0000_0001, 1'b0, w);
        wait_out("mulhu", 33);
        drive(OP_REG, 3'b000, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFE, 1'b0, w);
        wait_out("mul", 33);
        drive(OP_REG, 3'b010, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, w);
        wait_out("mulhsu", 33);

        // Divide family
        drive(OP_REG, 3'b100, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFD, 1'b0, w);
        wait_out("div", 33);
        drive(OP_REG, 3'b110, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, w);
        wait_out("rem", 33);
        drive(OP_REG, 3'b101, 7'b0000001, 32'd100, 32'd7, 32'd0, 32'd14, 1'b0, w);
        wait_out("divu", 33);
        drive(OP_REG, 3'b100, 7'b0000001, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, w);
        wait_out("div0", 0);
        drive(OP_REG, 3'b111, 7'b0000001, 32'd7, 32'd0, 32'd0, 32'd7, 1'b0, w);
        wait_out("remu0", 0);
        drive(OP_REG, 3'b100, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, w);
        wait_out("div_ovf", 0);
        drive(OP_REG, 3'b110, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b0, w);
        wait_out("rem_ovf", 0);

        // M ops flagged illegal when the extension is absent
        opcode = OP_REG; funct3 = 3'b000; funct7 = 7'b0000001;
        rs1_val = 32'hFFFF_FFFF; rs2_val = 32'd2;
        nm_in_valid = 1'b1;
        @(posedge clk); #1;
        nm_in_valid = 1'b0;
        chk("nom_valid", {63'd0, nm_out_valid}, 64'd1);
        chk("nom_illegal", {63'd0, nm_illegal}, 64'd1);
        chk("nom_result", {32'd0, nm_result}, 64'd0);
        @(posedge clk); #1;

        // Backpressure: held result, then new accept on the out_ready rise
        out_ready = 1'b0;
        drive(OP_REG, 3'b000, 7'b0000000, 32'd10, 32'd20, 32'd0, 32'd30, 1'b0, w);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_result", {32'd0, result}, 64'd30);
            chk("bp_illegal", {63'd0, illegal}, 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drive(OP_REG, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'd0, 32'd3, 1'b0, w);
        chk("bp_accept_waits", 64'(w), 64'd0);

        // Back-to-back ADDs, one per clock
        for (int i = 0; i < 10; i++) begin
            drive(OP_REG, 3'b000, 7'b0000000, 32'(i), 32'(100 + i), 32'd0, 32'(100 + 2 * i), 1'b0, w);
            chk("b2b_waits", 64'(w), 64'd0);
            chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        end
        @(posedge clk); #1;

        // Reset during iteration 10 of a DIVU
        drive(OP_REG, 3'b101, 7'b0000001, 32'd1000, 32'd3, 32'd0, 32'd333, 1'b0, w);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
        drive(OP_REG, 3'b000, 7'b0000000, 32'd3, 32'd4, 32'd0, 32'd7, 1'b0, w);
        wait_out("post_rst_add", 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
